// File: rtl/sys_skew_feeder.sv
// Edge feeder for the systolic array: accepts one lane vector per handshake, emits it
// diagonally skewed (lane k delayed k advances), then drains with zero vectors.
module sys_skew_feeder #(
  parameter int unsigned dataWidth    = 32,
  parameter int unsigned SysDimension = 32,
  parameter int unsigned featureLen   = 128,
  parameter int unsigned drainLen     = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [dataWidth*SysDimension-1:0]   in_vec,
  input  logic                                in_last,
  output logic [dataWidth*SysDimension-1:0]   out_vec,
  output logic                                sys_enable,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned NumRegs   = SysDimension * (SysDimension + 1) / 2;
  localparam int unsigned VecCntW   = $clog2(featureLen) + 1;
  localparam int unsigned FlushLast = SysDimension + drainLen - 2;
  localparam int unsigned DrainCntW = $clog2(FlushLast + 1) + 1;

  localparam logic [VecCntW-1:0]   LastIdx  = VecCntW'(featureLen - 1);
  localparam logic [DrainCntW-1:0] DrainEnd = DrainCntW'(FlushLast);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  // Lane k owns k+1 consecutive stages starting here; its last stage is the output register.
  function automatic int unsigned lane_base(input int unsigned k);
    return (k * (k + 1)) / 2;
  endfunction

  state_e                 state_q, state_d;
  logic [dataWidth-1:0]   skew_q [NumRegs];
  logic [dataWidth-1:0]   skew_d [NumRegs];
  logic                   sys_enable_q, sys_enable_d;
  logic                   done_q, done_d;
  logic [VecCntW-1:0]     vec_cnt_q, vec_cnt_d;
  logic [DrainCntW-1:0]   drain_cnt_q, drain_cnt_d;

  logic accept;
  logic last_eff;
  logic flush_end;
  logic adv;

  always_comb begin
    in_ready  = (state_q == STREAM);
    busy      = (state_q != IDLE);
    accept    = in_valid & in_ready;
    last_eff  = in_last | (vec_cnt_q == LastIdx);
    flush_end = (drain_cnt_q == DrainEnd);
    adv       = accept | (state_q == FLUSH);
  end

  // Skew chains: head loads new lane data while streaming, zeros while flushing.
  always_comb begin
    skew_d = skew_q;
    if (adv) begin
      for (int unsigned k = 0; k < SysDimension; k++) begin
        for (int unsigned j = 0; j <= k; j++) begin
          if (j == 0) begin
            skew_d[lane_base(k)] = (state_q == STREAM) ? in_vec[k*dataWidth +: dataWidth]
                                                       : '0;
          end else begin
            skew_d[lane_base(k) + j] = skew_q[lane_base(k) + j - 1];
          end
        end
      end
    end
  end

  always_comb begin
    out_vec = '0;
    for (int unsigned k = 0; k < SysDimension; k++) begin
      out_vec[k*dataWidth +: dataWidth] = skew_q[lane_base(k) + k];
    end
  end

  // Pass control: next state, counters and the registered strobes.
  always_comb begin
    state_d      = state_q;
    vec_cnt_d    = vec_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    done_d       = 1'b0;
    sys_enable_d = adv;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = STREAM;
          vec_cnt_d = '0;
        end
      end
      STREAM: begin
        if (accept) begin
          vec_cnt_d = vec_cnt_q + VecCntW'(1);
          if (last_eff) begin
            state_d     = FLUSH;
            drain_cnt_d = '0;
          end
        end
      end
      FLUSH: begin
        if (flush_end) begin
          state_d     = IDLE;
          drain_cnt_d = '0;
          done_d      = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + DrainCntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sys_enable_q <= 1'b0;
      done_q       <= 1'b0;
      vec_cnt_q    <= '0;
      drain_cnt_q  <= '0;
      for (int unsigned i = 0; i < NumRegs; i++) begin
        skew_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      sys_enable_q <= sys_enable_d;
      done_q       <= done_d;
      vec_cnt_q    <= vec_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      skew_q       <= skew_d;
    end
  end

  assign sys_enable = sys_enable_q;
  assign done       = done_q;

endmodule
